// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the subsystems it releases.
// The sequencer connects through the slave modport; the controlling side uses master.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  localparam int unsigned CUR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  all_ready;
  logic                  busy;
  logic                  timeout_err;
  logic [CUR_W-1:0]      cur_stage;

  modport master (
    output soft_rst_req, stage_ready,
    input  stage_rst_n, all_ready, busy, timeout_err, cur_stage
  );

  modport slave (
    input  soft_rst_req, stage_ready,
    output stage_rst_n, all_ready, busy, timeout_err, cur_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases per-subsystem active-low resets in order, each after the previous
// stage acks (or times out), spaced by a programmable gap; soft reset restarts.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  reset_sequencer_if.slave  bus
);

  localparam int unsigned CUR_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic [CUR_W-1:0] LAST_STG  = CUR_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic [CUR_W-1:0]      cur_q, cur_d;
  logic                  all_ready_q, all_ready_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  ready_sel;
  logic [NUM_STAGES-1:0] next_mask;
  logic                  ack;

  // Ready bit of the awaited stage and one-hot mask of the stage after it
  always_comb begin
    ready_sel = 1'b0;
    next_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (CUR_W'(i) == cur_q) ready_sel = bus.stage_ready[i];
      if (CUR_W'(i) == cur_q + CUR_W'(1)) next_mask[i] = 1'b1;
    end
  end

  // Next-state logic; soft reset overrides every other transition
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rst_n_d       = rst_n_q;
    cur_d         = cur_q;
    all_ready_d   = all_ready_q;
    timeout_err_d = timeout_err_q;
    ack           = 1'b0;

    if (bus.soft_rst_req) begin
      state_d       = ST_HOLD;
      cnt_d         = '0;
      rst_n_d       = '0;
      cur_d         = '0;
      all_ready_d   = 1'b0;
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            state_d    = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ready_sel) begin
            ack = 1'b1;
          end else if (ACK_TIMEOUT != 0) begin
            if (cnt_q == TO_LAST) begin
              ack           = 1'b1;
              timeout_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (ack) begin
            cnt_d = '0;
            if (cur_q == LAST_STG) begin
              state_d     = ST_DONE;
              all_ready_d = 1'b1;
            end else if (STAGE_GAP == 0) begin
              rst_n_d = rst_n_q | next_mask;
              cur_d   = cur_q + CUR_W'(1);
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            rst_n_d = rst_n_q | next_mask;
            cur_d   = cur_q + CUR_W'(1);
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    busy_d = ~all_ready_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      rst_n_q       <= '0;
      cur_q         <= '0;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_n_q       <= rst_n_d;
      cur_q         <= cur_d;
      all_ready_q   <= all_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.stage_rst_n = rst_n_q;
  assign bus.all_ready   = all_ready_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cur_stage   = cur_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: an edge-arithmetic reference model predicts every output change,
// a monitor pops predictions whenever the observed outputs change.
module tb_reset_sequencer;

  localparam int unsigned NS   = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned SW   = NS + 3 + CW;
  localparam int          MAXE = 1200;
  localparam logic [SW-1:0] RST_SNAP = {{NS{1'b0}}, 1'b0, 1'b1, 1'b0, {CW{1'b0}}};

  typedef struct packed {
    int            ed;
    logic [SW-1:0] snap;
  } ev_t;

  logic          clock;
  logic          rst_n;
  logic [NS-1:0] rdy_drv;
  logic          soft_drv;
  logic          mon_en;
  logic          sel;
  int            nvec;
  int            nmis;
  ev_t           exp_q[$];
  logic [NS-1:0] rdy_tab[MAXE];

  reset_sequencer_if #(.NUM_STAGES(NS)) if_a ();
  reset_sequencer_if #(.NUM_STAGES(NS)) if_b ();

  assign if_a.stage_ready  = rdy_drv;
  assign if_a.soft_rst_req = soft_drv;
  assign if_b.stage_ready  = rdy_drv;
  assign if_b.soft_rst_req = soft_drv;

  reset_sequencer #(.NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(8), .ACK_TIMEOUT(1024))
    dut_a (.clock(clock), .reset_n(rst_n), .bus(if_a.slave));

  reset_sequencer #(.NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(0), .ACK_TIMEOUT(0))
    dut_b (.clock(clock), .reset_n(rst_n), .bus(if_b.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [SW-1:0] snap_of(input logic b);
    if (b) return {if_b.stage_rst_n, if_b.all_ready, if_b.busy, if_b.timeout_err, if_b.cur_stage};
    return {if_a.stage_rst_n, if_a.all_ready, if_a.busy, if_a.timeout_err, if_a.cur_stage};
  endfunction

  // Record the expected output tuple after a given edge; same-edge updates merge
  function automatic void push(input int ed, input logic [NS-1:0] r, input logic ar,
                               input logic te, input int cs);
    logic [SW-1:0] s;
    ev_t ev;
    s = {r, ar, ~ar, te, CW'(cs)};
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].ed == ed) begin
      exp_q[exp_q.size()-1].snap = s;
    end else begin
      ev.ed = ed;
      ev.snap = s;
      exp_q.push_back(ev);
    end
  endfunction

  // Stage i released at edge r; acked at first edge e>r with ready[i] high, or at r+timeout.
  // Next release is ack+gap. Soft request over edges s0..s1 clears all, restarting at s1.
  task automatic model(input int gap, input int to, input int s0, input int s1, input int horizon);
    logic [NS-1:0] r_n;
    logic ar, te, hit_soft, fin, soft_pend;
    int cs, r, i, e;
    r_n = '0; ar = 1'b0; te = 1'b0; cs = 0;
    r = HOLD; i = 0; e = 0;
    soft_pend = (s0 > 0);
    fin = 1'b0;
    while (!fin) begin
      hit_soft = 1'b0;
      if (soft_pend && r >= s0) begin
        hit_soft = 1'b1;
      end else if (r > horizon) begin
        fin = 1'b1;
      end else begin
        r_n[i] = 1'b1;
        cs = i;
        push(r, r_n, ar, te, cs);
        e = r + 1;
        while (1) begin
          if (soft_pend && e >= s0) begin hit_soft = 1'b1; break; end
          if (e > horizon) begin fin = 1'b1; break; end
          if (rdy_tab[e][i]) break;
          if (to != 0 && e == r + to) begin
            if (!te) begin te = 1'b1; push(e, r_n, ar, te, cs); end
            break;
          end
          e++;
        end
        if (!hit_soft && !fin) begin
          if (i == NS - 1) begin
            ar = 1'b1;
            push(e, r_n, ar, te, cs);
            if (soft_pend) hit_soft = 1'b1;
            else fin = 1'b1;
          end else begin
            r = e + gap;
            i++;
          end
        end
      end
      if (hit_soft) begin
        if (s0 > horizon) begin
          fin = 1'b1;
        end else begin
          if (r_n != '0 || ar || te) begin
            r_n = '0; ar = 1'b0; te = 1'b0; cs = 0;
            push(s0, r_n, ar, te, cs);
          end
          soft_pend = 1'b0;
          r = s1 + HOLD;
          i = 0;
        end
      end
    end
  endtask

  task automatic fill_tab(input logic [NS-1:0] v);
    for (int e = 0; e < MAXE; e++) rdy_tab[e] = v;
  endtask

  task automatic rand_tab(input bit allow_stuck);
    int rise, p, d;
    for (int i = 0; i < NS; i++) begin
      rise = int'($urandom_range(1, 150));
      if (allow_stuck && $urandom_range(0, 7) == 0) rise = MAXE;
      for (int e = 0; e < MAXE; e++) rdy_tab[e][i] = (e >= rise);
      if ($urandom_range(0, 2) == 0) begin
        p = int'($urandom_range(1, 140));
        for (int k = 0; k <= int'($urandom_range(0, 3)); k++) rdy_tab[p + k][i] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        d = rise + int'($urandom_range(0, 100));
        for (int e = d; e < MAXE; e++) rdy_tab[e][i] = 1'b0;
      end
    end
  endtask

  // Hard reset between edges, predict, then drive the ready table edge by edge
  task automatic run(input logic use_b, input int s0, input int s1, input int horizon);
    logic [SW-1:0] got;
    @(posedge clock);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    got = snap_of(1'b0);
    nvec++;
    if (got !== RST_SNAP) begin
      nmis++;
      $display("FAIL reset_a: got %b expected %b", got, RST_SNAP);
    end
    got = snap_of(1'b1);
    nvec++;
    if (got !== RST_SNAP) begin
      nmis++;
      $display("FAIL reset_b: got %b expected %b", got, RST_SNAP);
    end
    sel = use_b;
    exp_q.delete();
    model(use_b ? 0 : 8, use_b ? 0 : 1024, s0, s1, horizon);
    rdy_drv = '0;
    soft_drv = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int e = 1; e <= horizon; e++) begin
      rdy_drv = rdy_tab[e];
      soft_drv = (s0 != 0 && e >= s0 && e <= s1);
      @(negedge clock);
    end
    mon_en = 1'b0;
    soft_drv = 1'b0;
    nvec++;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL pending_events: %0d predicted changes never seen, first at edge %0d",
               exp_q.size(), exp_q[0].ed);
      exp_q.delete();
    end
  endtask

  // Monitor: each observed output change must match the oldest prediction
  initial begin : monitor
    logic [SW-1:0] prev, cur;
    int edge_n;
    ev_t ev;
    prev = RST_SNAP;
    edge_n = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!mon_en) begin
        prev = RST_SNAP;
        edge_n = 0;
      end else begin
        edge_n++;
        cur = snap_of(sel);
        if (cur !== prev) begin
          nvec++;
          if (exp_q.size() == 0) begin
            nmis++;
            $display("FAIL unexpected_change edge %0d: got %b, expected unchanged %b",
                     edge_n, cur, prev);
          end else begin
            ev = exp_q.pop_front();
            if (ev.ed != edge_n || ev.snap !== cur) begin
              nmis++;
              $display("FAIL event: got %b at edge %0d, expected %b at edge %0d",
                       cur, edge_n, ev.snap, ev.ed);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    nvec = 0;
    nmis = 0;
    rst_n = 1'b0;
    rdy_drv = '0;
    soft_drv = 1'b0;
    mon_en = 1'b0;
    sel = 1'b0;

    fill_tab('1);
    run(1'b0, 0, 0, 60);
    for (int e = 50; e < MAXE; e++) rdy_tab[e] = '0;
    run(1'b0, 0, 0, 80);
    fill_tab(4'b1011);
    run(1'b0, 0, 0, 1080);
    fill_tab('1);
    run(1'b0, 30, 30, 70);
    run(1'b0, 30, 49, 90);
    run(1'b1, 0, 0, 30);
    fill_tab(4'b1101);
    run(1'b1, 0, 0, 200);
    fill_tab(4'b1101);
    rdy_tab[20][1] = 1'b1;
    rdy_tab[21][1] = 1'b1;
    for (int e = 40; e < MAXE; e++) rdy_tab[e][1] = 1'b1;
    run(1'b0, 0, 0, 100);

    for (int n = 0; n < 24; n++) begin
      int s0, s1;
      logic b;
      b = 1'(n % 2);
      rand_tab(1'b1);
      s0 = 0;
      s1 = 0;
      if ($urandom_range(0, 2) == 0) begin
        s0 = int'($urandom_range(5, 150));
        s1 = s0 + int'($urandom_range(0, 20));
      end
      run(b, s0, s1, 240);
    end

    fill_tab('1);
    run(1'b0, 0, 0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
